hazard_unit: RTL and testbench

Forwarding and load-use hazard controller for the five-stage pipelined datapath. It watches each instruction as it leaves the instruction fetch unit and computes the four forwarding selects (`ex_forward_a/b`, `mem_forward_a/b`) that the datapath registers into IF/ID alongside the instruction. It keeps its own two-deep history of in-flight destination registers. When a load result cannot be forwarded in time, it stalls fetch for one cycle and injects a NOP bubble.

---
 rtl/hazard_unit.sv | 135 +++++++++++++
 tb/tb_hazard_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Forwarding-select and load-use stall controller fed from the fetch stage.
// All outputs are combinational from instr_in and a two-deep destination history.
module hazard_unit #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            instr_in,
  output logic                   ex_forward_a,
  output logic                   ex_forward_b,
  output logic                   mem_forward_a,
  output logic                   mem_forward_b,
  output logic                   stall,
  output logic                   bubble,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef enum logic {RUN, STALL} state_t;

  state_t                 state_q, state_d;
  logic                   h1_vld_q, h1_vld_d, h1_load_q, h1_load_d;
  logic [4:0]             h1_dest_q, h1_dest_d;
  logic                   h2_vld_q, h2_vld_d, h2_load_q, h2_load_d;
  logic [4:0]             h2_dest_q, h2_dest_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  logic       unused_funct;
  logic       has_dest, use_rs, use_rt, is_load, dec_vld;
  logic [4:0] dec_dest;

  assign op           = instr_in[31:26];
  assign rs           = instr_in[25:21];
  assign rt           = instr_in[20:16];
  assign rd           = instr_in[15:11];
  assign unused_funct = ^instr_in[10:0];

  always_comb begin
    has_dest = 1'b0;
    dec_dest = 5'd0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    is_load  = 1'b0;
    case (op)
      6'h00: begin
        has_dest = 1'b1; dec_dest = rd; use_rs = 1'b1; use_rt = 1'b1;
      end
      6'h08, 6'h0C, 6'h0D: begin
        has_dest = 1'b1; dec_dest = rt; use_rs = 1'b1;
      end
      6'h23: begin
        has_dest = 1'b1; dec_dest = rt; use_rs = 1'b1; is_load = 1'b1;
      end
      6'h2B, 6'h04: begin
        use_rs = 1'b1; use_rt = 1'b1;
      end
      default: ;
    endcase
  end

  // A write to $0 is never a real producer, so it never enters history.
  assign dec_vld = has_dest && (dec_dest != 5'd0);

  logic chk_rs, chk_rt;
  logic h1_rs, h1_rt, h2_rs, h2_rt;
  logic load_use;

  assign chk_rs = use_rs && (rs != 5'd0);
  assign chk_rt = use_rt && (rt != 5'd0);
  assign h1_rs  = chk_rs && h1_vld_q && (h1_dest_q == rs);
  assign h1_rt  = chk_rt && h1_vld_q && (h1_dest_q == rt);
  assign h2_rs  = chk_rs && h2_vld_q && (h2_dest_q == rs);
  assign h2_rt  = chk_rt && h2_vld_q && (h2_dest_q == rt);

  assign load_use = (state_q == RUN) && h1_load_q && (h1_rs || h1_rt);

  always_comb begin
    ex_forward_a  = 1'b0;
    ex_forward_b  = 1'b0;
    mem_forward_a = 1'b0;
    mem_forward_b = 1'b0;
    stall         = 1'b0;
    bubble        = 1'b0;
    stall_count   = '0;
    if (!rst) begin
      stall_count = cnt_q;
      if (load_use) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end else begin
        ex_forward_a  = h1_rs && !h1_load_q;
        ex_forward_b  = h1_rt && !h1_load_q;
        mem_forward_a = h2_rs && !h1_rs;
        mem_forward_b = h2_rt && !h1_rt;
      end
    end
  end

  always_comb begin
    state_d   = RUN;
    if (state_q == RUN && load_use) state_d = STALL;
    h2_vld_d  = h1_vld_q;
    h2_dest_d = h1_dest_q;
    h2_load_d = h1_load_q;
    h1_vld_d  = dec_vld && !load_use;
    h1_dest_d = dec_dest;
    h1_load_d = is_load;
    cnt_d     = cnt_q;
    if (load_use && (cnt_q != {STALL_CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      h1_vld_q  <= 1'b0;
      h1_dest_q <= 5'd0;
      h1_load_q <= 1'b0;
      h2_vld_q  <= 1'b0;
      h2_dest_q <= 5'd0;
      h2_load_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      h1_vld_q  <= h1_vld_d;
      h1_dest_q <= h1_dest_d;
      h1_load_q <= h1_load_d;
      h2_vld_q  <= h2_vld_d;
      h2_dest_q <= h2_dest_d;
      h2_load_q <= h2_load_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: expectations queued at drive time, checked mid-cycle.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in;
  logic        ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b;
  logic        stall, bubble;
  logic [15:0] stall_count;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [5:0]  outs;   // {ex_a, ex_b, mem_a, mem_b, stall, bubble}
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  hazard_unit #(.STALL_CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_in      (instr_in),
    .ex_forward_a  (ex_forward_a),
    .ex_forward_b  (ex_forward_b),
    .mem_forward_a (mem_forward_a),
    .mem_forward_b (mem_forward_b),
    .stall         (stall),
    .bubble        (bubble),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic logic [31:0] rtype(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    return {6'h00, s, t, d, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] t, input logic [4:0] s);
    return {op, s, t, 16'h0004};
  endfunction

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [31:0] JMP  = {6'h02, 26'h000_0040};

  // Drive one cycle of stimulus, queue its expectation, then check in the low phase.
  task automatic step(input string tag, input logic r, input logic [31:0] ins,
                      input logic [5:0] outs, input logic [15:0] cnt);
    exp_t e, g;
    @(posedge clk);
    #1;
    rst      = r;
    instr_in = ins;
    e.tag = tag; e.outs = outs; e.cnt = cnt;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    n_assert++;
    assert ({ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b, stall, bubble} === g.outs)
      else begin
        n_fail++;
        $error("FAIL %s outs observed=%b expected=%b", g.tag,
               {ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b, stall, bubble}, g.outs);
      end
    n_assert++;
    assert (stall_count === g.cnt)
      else begin
        n_fail++;
        $error("FAIL %s stall_count observed=%0d expected=%0d", g.tag, stall_count, g.cnt);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    instr_in = NOP;
    // Reset
    step("rst0",      1, NOP, 6'b000000, 0);
    step("rst1",      1, NOP, 6'b000000, 0);
    step("nop0",      0, NOP, 6'b000000, 0);
    step("nop1",      0, NOP, 6'b000000, 0);
    // EX forward
    step("ex_add",    0, rtype(3, 1, 2), 6'b000000, 0);
    step("ex_sub",    0, rtype(4, 3, 5), 6'b100000, 0);
    step("f0",        0, NOP, 6'b000000, 0);
    step("f1",        0, NOP, 6'b000000, 0);
    // EX over MEM priority
    step("pri_a1",    0, rtype(3, 1, 2), 6'b000000, 0);
    step("pri_a2",    0, rtype(3, 1, 2), 6'b000000, 0);
    step("pri_or",    0, rtype(6, 3, 3), 6'b110000, 0);
    step("f2",        0, NOP, 6'b000000, 0);
    step("f3",        0, NOP, 6'b000000, 0);
    // MEM forward only
    step("mem_a1",    0, rtype(3, 1, 2), 6'b000000, 0);
    step("mem_a7",    0, rtype(7, 1, 2), 6'b000000, 0);
    step("mem_or",    0, rtype(6, 3, 3), 6'b001100, 0);
    step("f4",        0, NOP, 6'b000000, 0);
    step("f5",        0, NOP, 6'b000000, 0);
    // sw uses rs and rt
    step("sw_add",    0, rtype(3, 1, 2), 6'b000000, 0);
    step("sw_use",    0, itype(OP_SW, 3, 3), 6'b110000, 0);
    step("f6",        0, NOP, 6'b000000, 0);
    step("f7",        0, NOP, 6'b000000, 0);
    // Load-use
    step("lu_lw",     0, itype(OP_LW, 2, 1), 6'b000000, 0);
    step("lu_stall",  0, rtype(4, 2, 2), 6'b000011, 0);
    step("lu_repres", 0, rtype(4, 2, 2), 6'b001100, 1);
    step("lu_after",  0, NOP, 6'b000000, 1);
    // $0 destination and non-user
    step("z_nop",     0, NOP, 6'b000000, 1);
    step("z_lw0",     0, itype(OP_LW, 0, 1), 6'b000000, 1);
    step("z_add",     0, rtype(4, 0, 0), 6'b000000, 1);
    step("j_lw",      0, itype(OP_LW, 2, 1), 6'b000000, 1);
    step("j_jump",    0, JMP, 6'b000000, 1);
    step("f8",        0, NOP, 6'b000000, 1);
    step("f9",        0, NOP, 6'b000000, 1);
    // Back-to-back dependent loads: two separate stalls
    step("bb_lw2",    0, itype(OP_LW, 2, 1), 6'b000000, 1);
    step("bb_lw5",    0, itype(OP_LW, 5, 2), 6'b000011, 1);
    step("bb_lw5r",   0, itype(OP_LW, 5, 2), 6'b001000, 2);
    step("bb_add",    0, rtype(6, 5, 0), 6'b000011, 2);
    step("bb_addr",   0, rtype(6, 5, 0), 6'b001000, 3);
    step("f10",       0, NOP, 6'b000000, 3);
    step("f11",       0, NOP, 6'b000000, 3);
    // Load, unrelated, dependent: MEM forward, no stall
    step("gap_lw",    0, itype(OP_LW, 8, 1), 6'b000000, 3);
    step("gap_unrel", 0, rtype(9, 1, 1), 6'b000000, 3);
    step("gap_dep",   0, rtype(10, 8, 0), 6'b001000, 3);
    step("f12",       0, NOP, 6'b000000, 3);
    step("f13",       0, NOP, 6'b000000, 3);
    // Reset during the stall cycle
    step("rs_lw",     0, itype(OP_LW, 2, 1), 6'b000000, 3);
    step("rs_stall",  0, rtype(4, 2, 2), 6'b000011, 3);
    step("rs_inrst",  1, rtype(4, 2, 2), 6'b000000, 0);
    step("rs_repres", 0, rtype(4, 2, 2), 6'b000000, 0);
    step("rs_next",   0, rtype(4, 2, 2), 6'b000000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
